// File: rtl/sha_256_pad.sv
// FIPS 180-4 message padder for sha_256: packs a 32-bit byte stream into 512-bit
// blocks, appends 0x80 / zero fill / 64-bit bit length, and handshakes each block with the core.
module sha_256_pad #(
   parameter int unsigned CNT_W = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [31:0]  in_data,
   input  logic         in_last,
   input  logic [2:0]   in_bytes,
   input  logic [1:0]   op_sel,
   output logic [511:0] Data,
   output logic [63:0]  Index,
   output logic [1:0]   Operation,
   output logic         Enable,
   input  logic         Ready,
   output logic         busy,
   output logic         msg_done
);

   localparam int unsigned BLK_W  = 512;
   localparam int unsigned WORD_W = 32;
   localparam int unsigned IDX_W  = 64;

   localparam logic [1:0] FILL  = 2'd0;
   localparam logic [1:0] SEND  = 2'd1;
   localparam logic [1:0] WAIT  = 2'd2;
   localparam logic [1:0] EXTRA = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [3:0]       word_cnt_q, word_cnt_d;
   logic [CNT_W-1:0] bit_len_q, bit_len_d;
   logic [IDX_W-1:0] index_q, index_d;
   logic [BLK_W-1:0] data_q, data_d;
   logic [1:0]       op_q, op_d;
   logic             enable_q, enable_d;
   logic             busy_q, busy_d;
   logic             in_ready_q, in_ready_d;
   logic             final_q, final_d;   // current block carries the length field
   logic             extra_q, extra_d;   // length did not fit; one more block to send
   logic             defer_q, defer_d;   // 0x80 marker belongs to word 0 of the extra block

   logic [2:0]       nbytes;
   logic [63:0]      len64;
   int               pos;

   // Next-state, buffer update and padding placement
   always_comb begin
      state_d    = state_q;
      word_cnt_d = word_cnt_q;
      bit_len_d  = bit_len_q;
      index_d    = index_q;
      data_d     = data_q;
      op_d       = op_q;
      busy_d     = busy_q;
      final_d    = final_q;
      extra_d    = extra_q;
      defer_d    = defer_q;
      msg_done   = 1'b0;
      nbytes     = 3'd4;
      len64      = '0;
      pos        = 0;

      unique case (state_q)
         FILL: begin
            if (in_valid && in_ready_q) begin
               if (!busy_q) begin
                  op_d   = op_sel;
                  busy_d = 1'b1;
               end
               nbytes    = (in_last && (in_bytes < 3'd4)) ? in_bytes : 3'd4;
               bit_len_d = bit_len_q + CNT_W'({nbytes, 3'b000});
               if (!in_last) begin
                  data_d[WORD_W*int'(word_cnt_q) +: WORD_W] = in_data;
                  word_cnt_d = word_cnt_q + 4'd1;
                  if (word_cnt_q == 4'd15) state_d = SEND;
               end else begin
                  pos = 4*int'(word_cnt_q) + int'(nbytes);
                  // Byte j of the block lives in word j/4, MSB-first within the word
                  for (int j = 0; j < 64; j++) begin
                     if (j >= 4*int'(word_cnt_q)) begin
                        if (j < pos)
                           data_d[(j/4)*32 + 24 - 8*(j%4) +: 8] = in_data[24 - 8*(j%4) +: 8];
                        else if (j == pos)
                           data_d[(j/4)*32 + 24 - 8*(j%4) +: 8] = 8'h80;
                        else
                           data_d[(j/4)*32 + 24 - 8*(j%4) +: 8] = 8'h00;
                     end
                  end
                  len64 = 64'(bit_len_d);
                  if (pos <= 55) begin
                     data_d[14*WORD_W +: WORD_W] = len64[63:32];
                     data_d[15*WORD_W +: WORD_W] = len64[31:0];
                     final_d = 1'b1;
                  end else begin
                     extra_d = 1'b1;
                     defer_d = (pos == 64);
                  end
                  state_d = SEND;
               end
            end
         end
         SEND: state_d = WAIT;
         WAIT: begin
            if (Ready) begin
               if (final_q) begin
                  msg_done   = 1'b1;
                  index_d    = '0;
                  busy_d     = 1'b0;
                  bit_len_d  = '0;
                  word_cnt_d = '0;
                  final_d    = 1'b0;
                  state_d    = FILL;
               end else if (extra_q) begin
                  index_d = index_q + 64'd1;
                  state_d = EXTRA;
               end else begin
                  index_d    = index_q + 64'd1;
                  word_cnt_d = '0;
                  state_d    = FILL;
               end
            end
         end
         EXTRA: begin
            data_d = '0;
            if (defer_q) data_d[WORD_W-1:0] = 32'h8000_0000;
            len64 = 64'(bit_len_q);
            data_d[14*WORD_W +: WORD_W] = len64[63:32];
            data_d[15*WORD_W +: WORD_W] = len64[31:0];
            final_d = 1'b1;
            extra_d = 1'b0;
            defer_d = 1'b0;
            state_d = SEND;
         end
         default: state_d = FILL;
      endcase

      enable_d   = (state_d == SEND);
      in_ready_d = (state_d == FILL);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= FILL;
         word_cnt_q <= '0;
         bit_len_q  <= '0;
         index_q    <= '0;
         data_q     <= '0;
         op_q       <= '0;
         enable_q   <= 1'b0;
         busy_q     <= 1'b0;
         in_ready_q <= 1'b1;
         final_q    <= 1'b0;
         extra_q    <= 1'b0;
         defer_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         word_cnt_q <= word_cnt_d;
         bit_len_q  <= bit_len_d;
         index_q    <= index_d;
         data_q     <= data_d;
         op_q       <= op_d;
         enable_q   <= enable_d;
         busy_q     <= busy_d;
         in_ready_q <= in_ready_d;
         final_q    <= final_d;
         extra_q    <= extra_d;
         defer_q    <= defer_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign Data      = data_q;
   assign Index     = index_q;
   assign Operation = op_q;
   assign Enable    = enable_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_sha_256_pad.sv
// Bench for sha_256_pad: a model pads each message as a byte queue and the bench
// plays the sha_256 core, checking every block it is handed.
module tb_sha_256_pad;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [31:0]  in_data;
   logic         in_last;
   logic [2:0]   in_bytes;
   logic [1:0]   op_sel;
   logic [511:0] Data;
   logic [63:0]  Index;
   logic [1:0]   Operation;
   logic         Enable;
   logic         Ready;
   logic         busy;
   logic         msg_done;

   sha_256_pad #(.CNT_W(64)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_last(in_last), .in_bytes(in_bytes), .op_sel(op_sel),
      .Data(Data), .Index(Index), .Operation(Operation), .Enable(Enable),
      .Ready(Ready), .busy(busy), .msg_done(msg_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          kind;    // 0 random, 1 "abc", 2 NIST 56-byte string, 3 incrementing bytes
      int          len;
      logic [1:0]  op;
      int          dly;
      int          blocks;
      logic [31:0] w0;      // word 0 of final block
      logic [31:0] w15;     // word 15 of final block
   } vec_t;

   int           n_chk = 0;
   int           n_fail = 0;
   int           enables_seen;
   byte unsigned msg_q[$];
   logic [511:0] exp_blk[$];
   logic [511:0] last_data;
   vec_t         vt[10];

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic make_msg(input int kind, input int len);
      string s;
      msg_q.delete();
      s = (kind == 1) ? "abc" : "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
      for (int i = 0; i < len; i++) begin
         case (kind)
            1, 2:    msg_q.push_back(s[i]);
            3:       msg_q.push_back(8'(i));
            default: msg_q.push_back(8'($urandom));
         endcase
      end
   endtask

   // Reference padding: message, 0x80, zeros to 56 mod 64, 64-bit big-endian bit length
   task automatic build_blocks();
      byte unsigned p[$];
      logic [63:0]  bl;
      logic [511:0] blk;
      p = msg_q;
      bl = 64'(msg_q.size()) * 64'd8;
      p.push_back(8'h80);
      while (p.size() % 64 != 56) p.push_back(8'h00);
      for (int i = 7; i >= 0; i--) p.push_back(bl[i*8 +: 8]);
      exp_blk.delete();
      for (int b = 0; b < p.size() / 64; b++) begin
         blk = '0;
         for (int j = 0; j < 64; j++) blk[(j/4)*32 + 24 - 8*(j%4) +: 8] = p[b*64 + j];
         exp_blk.push_back(blk);
      end
   endtask

   task automatic drive_msg();
      int          n;
      int          beats;
      int          rem;
      int          nb;
      int          t;
      bit          last;
      logic [31:0] w;
      n = msg_q.size();
      beats = (n + 3) / 4;
      if (beats == 0) beats = 1;
      for (int k = 0; k < beats; k++) begin
         rem  = n - 4*k;
         last = (k == beats - 1);
         nb   = last ? rem : 4;
         w    = $urandom;
         for (int i = 0; i < nb; i++) w[24 - 8*i +: 8] = msg_q[4*k + i];
         if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
         end
         in_valid = 1'b1;
         in_data  = w;
         in_last  = last;
         if (last) in_bytes = (nb == 4 && $urandom_range(0, 1) == 1) ? 3'($urandom_range(4, 7)) : 3'(nb);
         else      in_bytes = 3'($urandom);
         t = 0;
         while (!in_ready && t < 5000) begin @(posedge clk); #1; t++; end
         if (!in_ready) begin
            chk("in_ready_timeout", 512'(in_ready), 512'(1));
            break;
         end
         @(posedge clk); #1;
         if (k == 0) op_sel = 2'($urandom);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic core_msg(input logic [1:0] op, input int dly);
      int  t;
      int  nblk;
      bit  fin;
      nblk = exp_blk.size();
      for (int b = 0; b < nblk; b++) begin
         fin = (b == nblk - 1);
         t = 0;
         while (!Enable && t < 5000) begin @(posedge clk); #1; t++; end
         chk("enable_seen", 512'(Enable), 512'(1));
         if (!Enable) break;
         enables_seen++;
         chk("data", Data, exp_blk[b]);
         chk("index", 512'(Index), 512'(b));
         chk("operation", 512'(Operation), 512'(op));
         chk("busy", 512'(busy), 512'(1));
         if (fin) last_data = Data;
         for (int d = 0; d < dly; d++) begin
            @(posedge clk); #1;
            chk("enable_pulse", 512'(Enable), 512'(0));
            chk("data_stable", Data, exp_blk[b]);
            chk("in_ready_wait", 512'(in_ready), 512'(0));
         end
         Ready = 1'b1;
         #1;
         chk("msg_done", 512'(msg_done), 512'(fin));
         chk("enable_at_ready", 512'(Enable), 512'(0));
         @(posedge clk); #1;
         Ready = 1'b0;
         chk("enable_after_ready", 512'(Enable), 512'(0));
         if (fin) begin
            chk("busy_end", 512'(busy), 512'(0));
            chk("index_end", 512'(Index), 512'(0));
         end
      end
   endtask

   task automatic run_msg(input int kind, input int len, input logic [1:0] op, input int dly);
      make_msg(kind, len);
      build_blocks();
      enables_seen = 0;
      op_sel = op;
      fork
         drive_msg();
         core_msg(op, dly);
      join
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         if (Enable) enables_seen++;
      end
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_in_ready"}, 512'(in_ready), 512'(1));
      chk({tag, "_enable"}, 512'(Enable), 512'(0));
      chk({tag, "_busy"}, 512'(busy), 512'(0));
      chk({tag, "_index"}, 512'(Index), 512'(0));
      chk({tag, "_data"}, Data, 512'(0));
      chk({tag, "_operation"}, 512'(Operation), 512'(0));
      chk({tag, "_msg_done"}, 512'(msg_done), 512'(0));
   endtask

   initial begin
      int t;
      vt[0] = '{1, 3,   2'd1, 3,   1, 32'h6162_6380, 32'h0000_0018};
      vt[1] = '{0, 0,   2'd1, 1,   1, 32'h8000_0000, 32'h0000_0000};
      vt[2] = '{2, 56,  2'd1, 2,   2, 32'h0000_0000, 32'h0000_01C0};
      vt[3] = '{0, 64,  2'd1, 4,   2, 32'h8000_0000, 32'h0000_0200};
      vt[4] = '{1, 3,   2'd0, 1,   1, 32'h6162_6380, 32'h0000_0018};
      vt[5] = '{1, 3,   2'd1, 200, 1, 32'h6162_6380, 32'h0000_0018};
      vt[6] = '{3, 55,  2'd0, 2,   1, 32'h0001_0203, 32'h0000_01B8};
      vt[7] = '{3, 60,  2'd1, 1,   2, 32'h0000_0000, 32'h0000_01E0};
      vt[8] = '{3, 119, 2'd1, 3,   2, 32'h4041_4243, 32'h0000_03B8};
      vt[9] = '{3, 120, 2'd0, 1,   3, 32'h0000_0000, 32'h0000_03C0};

      rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; in_bytes = '0;
      op_sel = '0; Ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk_reset_state("reset");

      for (int i = 0; i < 10; i++) begin
         run_msg(vt[i].kind, vt[i].len, vt[i].op, vt[i].dly);
         chk($sformatf("vec%0d_blocks", i), 512'(enables_seen), 512'(vt[i].blocks));
         chk($sformatf("vec%0d_last_w0", i), 512'(last_data[31:0]), 512'(vt[i].w0));
         chk($sformatf("vec%0d_last_w15", i), 512'(last_data[511:480]), 512'(vt[i].w15));
      end

      // Reset while the core holds a block
      in_valid = 1'b1; in_data = 32'h6162_6300; in_last = 1'b1; in_bytes = 3'd3; op_sel = 2'd1;
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0;
      t = 0;
      while (!Enable && t < 100) begin @(posedge clk); #1; t++; end
      chk("rst_wait_enable", 512'(Enable), 512'(1));
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk_reset_state("rst_wait");

      // Ready outside WAIT has no effect
      Ready = 1'b1; #1;
      chk("stray_ready_done", 512'(msg_done), 512'(0));
      @(posedge clk); #1;
      Ready = 1'b0;
      chk("stray_ready_enable", 512'(Enable), 512'(0));
      chk("stray_ready_in_ready", 512'(in_ready), 512'(1));

      run_msg(1, 3, 2'd1, 2);
      chk("after_rst_blocks", 512'(enables_seen), 512'(1));

      // Reset part-way through a message
      for (int k = 0; k < 5; k++) begin
         in_valid = 1'b1; in_data = $urandom; in_last = 1'b0; in_bytes = 3'd4;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("mid_rst_busy", 512'(busy), 512'(0));
      run_msg(3, 70, 2'd0, 1);
      chk("mid_rst_blocks", 512'(enables_seen), 512'(2));

      for (int r = 0; r < 12; r++) begin
         run_msg($urandom_range(0, 3) == 0 ? 3 : 0, $urandom_range(0, 200),
                 2'($urandom_range(0, 1)), $urandom_range(1, 6));
         chk($sformatf("rand%0d_blocks", r), 512'(enables_seen), 512'(exp_blk.size()));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
